// File: rtl/pad_pkg.sv
// Shared definitions for the gated pad clock burst generator.
//   pad_sclk_state_e   : burst FSM states (idle, active half, rest half)
//   PAD_CLK_HZ_DEFAULT : nominal pad clock rate
//   SYS_CLK_HZ_DEFAULT : nominal system clock rate
//   half_div()         : system clocks per pad clock half-period
package pad_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACT  = 2'd1,
        REST = 2'd2
    } pad_sclk_state_e;

    localparam int PAD_CLK_HZ_DEFAULT = 500_000;
    localparam int SYS_CLK_HZ_DEFAULT = 50_000_000;

    function automatic int half_div(input int clk_hz, input int sclk_hz);
        return clk_hz / (2 * sclk_hz);
    endfunction

endpackage

// File: rtl/pad_sclk_burst_gen_if.sv
// Handshake/pad bundle between the transaction sequencer and the burst generator.
//   start, nbits, abort          : requests from the sequencer (master drives)
//   pad_clk                      : pad clock to the pin
//   lead_stb, trail_stb          : shift / sample strobes in the system clock domain
//   bit_idx, busy, done          : burst progress and completion
interface pad_sclk_burst_gen_if #(
    parameter int NBITS_MAX = 8
) ();
    import pad_pkg::*;

    localparam int NB_W = $clog2(NBITS_MAX + 1);

    logic            start;
    logic [NB_W-1:0] nbits;
    logic            abort;
    logic            pad_clk;
    logic            lead_stb;
    logic            trail_stb;
    logic [NB_W-1:0] bit_idx;
    logic            busy;
    logic            done;

    modport master (
        output start, nbits, abort,
        input  pad_clk, lead_stb, trail_stb, bit_idx, busy, done
    );

    modport slave (
        input  start, nbits, abort,
        output pad_clk, lead_stb, trail_stb, bit_idx, busy, done
    );

endinterface

// File: rtl/pad_half_tick.sv
// Half-period counter for the pad clock generator.
//   clk_50mhz : system clock
//   rst_n     : synchronous active-low reset
//   clr       : synchronous clear (takes effect at the next edge)
//   tc        : high while the count sits at HALF_DIV-1
module pad_half_tick
    import pad_pkg::*;
#(
    parameter int HALF_DIV = 50
) (
    input  logic clk_50mhz,
    input  logic rst_n,
    input  logic clr,
    output logic tc
);

    localparam int              CNT_W  = $clog2(HALF_DIV);
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(HALF_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc = (cnt_q == TC_VAL);

    // Wrap on terminal count so the counter never leaves 0..HALF_DIV-1.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || tc) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pad_sclk_burst_gen.sv
// Gated pad clock burst generator. Emits exactly nbits pad clock cycles per
// accepted request, holding IDLE_LEVEL between bursts, and produces one-cycle
// lead (shift) / trail (sample) strobes aligned with the pad clock edges.
//   clk_50mhz : system clock
//   rst_n     : synchronous active-low reset
//   bus       : slave side of pad_sclk_burst_gen_if (start/nbits/abort in,
//               pad_clk/lead_stb/trail_stb/bit_idx/busy/done out, all registered)
module pad_sclk_burst_gen
    import pad_pkg::*;
#(
    parameter int   HALF_DIV   = half_div(SYS_CLK_HZ_DEFAULT, PAD_CLK_HZ_DEFAULT),
    parameter logic IDLE_LEVEL = 1'b1,
    parameter int   NBITS_MAX  = 8
) (
    input  logic                clk_50mhz,
    input  logic                rst_n,
    pad_sclk_burst_gen_if.slave bus
);

    localparam int              NB_W   = $clog2(NBITS_MAX + 1);
    localparam logic [NB_W-1:0] NB_MAX = NB_W'(NBITS_MAX);

    pad_sclk_state_e state_q, state_d;
    logic            pad_clk_q, pad_clk_d;
    logic            lead_q, lead_d;
    logic            trail_q, trail_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [NB_W-1:0] bit_idx_q, bit_idx_d;
    logic [NB_W-1:0] nbits_q, nbits_d;

    logic tc;
    logic half_clr;

    // The half counter restarts on every state change and is parked at zero
    // while idle, so each ACT/REST half lasts exactly HALF_DIV cycles.
    assign half_clr = (state_d != state_q) || (state_q == IDLE);

    pad_half_tick #(
        .HALF_DIV (HALF_DIV)
    ) u_half_tick (
        .clk_50mhz (clk_50mhz),
        .rst_n     (rst_n),
        .clr       (half_clr),
        .tc        (tc)
    );

    always_comb begin
        state_d   = state_q;
        pad_clk_d = pad_clk_q;
        lead_d    = 1'b0;
        trail_d   = 1'b0;
        done_d    = 1'b0;
        busy_d    = busy_q;
        bit_idx_d = bit_idx_q;
        nbits_d   = nbits_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.nbits == '0) begin
                        // Zero-length burst completes immediately, pad untouched.
                        done_d = 1'b1;
                    end else begin
                        state_d   = ACT;
                        pad_clk_d = ~IDLE_LEVEL;
                        lead_d    = 1'b1;
                        busy_d    = 1'b1;
                        bit_idx_d = '0;
                        nbits_d   = (bus.nbits > NB_MAX) ? NB_MAX : bus.nbits;
                    end
                end
            end
            ACT: begin
                if (bus.abort) begin
                    // Forced trailing edge deliberately raises no strobe.
                    state_d   = IDLE;
                    pad_clk_d = IDLE_LEVEL;
                    busy_d    = 1'b0;
                end else if (tc) begin
                    state_d   = REST;
                    pad_clk_d = IDLE_LEVEL;
                    trail_d   = 1'b1;
                end
            end
            REST: begin
                if (bus.abort) begin
                    state_d   = IDLE;
                    pad_clk_d = IDLE_LEVEL;
                    busy_d    = 1'b0;
                end else if (tc) begin
                    if (bit_idx_q < nbits_q - NB_W'(1)) begin
                        state_d   = ACT;
                        pad_clk_d = ~IDLE_LEVEL;
                        lead_d    = 1'b1;
                        bit_idx_d = bit_idx_q + NB_W'(1);
                    end else begin
                        // The final REST half doubles as the trailing idle gap.
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                pad_clk_d = IDLE_LEVEL;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pad_clk_q <= IDLE_LEVEL;
            lead_q    <= 1'b0;
            trail_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bit_idx_q <= '0;
            nbits_q   <= '0;
        end else begin
            state_q   <= state_d;
            pad_clk_q <= pad_clk_d;
            lead_q    <= lead_d;
            trail_q   <= trail_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bit_idx_q <= bit_idx_d;
            nbits_q   <= nbits_d;
        end
    end

    assign bus.pad_clk   = pad_clk_q;
    assign bus.lead_stb  = lead_q;
    assign bus.trail_stb = trail_q;
    assign bus.bit_idx   = bit_idx_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_pad_sclk_burst_gen.sv
// Bench for pad_sclk_burst_gen: two instances (HALF_DIV=50/IDLE_LEVEL=1 and
// HALF_DIV=2/IDLE_LEVEL=0) checked every cycle against a timing-formula model:
// a burst accepted at edge k with length n is busy for 2nH cycles, leads at
// k+2iH, trails at k+(2i+1)H and reports done at k+2nH.
module tb_pad_sclk_burst_gen;
    import pad_pkg::*;

    localparam int   NMAX = 8;
    localparam int   H0   = 50;
    localparam int   H1   = 2;
    localparam logic IL0  = 1'b1;
    localparam logic IL1  = 1'b0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pad_sclk_burst_gen_if #(.NBITS_MAX(NMAX)) bus0 ();
    pad_sclk_burst_gen_if #(.NBITS_MAX(NMAX)) bus1 ();

    pad_sclk_burst_gen #(.HALF_DIV(H0), .IDLE_LEVEL(IL0), .NBITS_MAX(NMAX)) dut0 (
        .clk_50mhz (clk),
        .rst_n     (rst_n),
        .bus       (bus0)
    );

    pad_sclk_burst_gen #(.HALF_DIV(H1), .IDLE_LEVEL(IL1), .NBITS_MAX(NMAX)) dut1 (
        .clk_50mhz (clk),
        .rst_n     (rst_n),
        .bus       (bus1)
    );

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   hd[2] = '{H0, H1};
    logic il[2] = '{IL0, IL1};

    // Model state: burst accepted (act) at edge kk with clamped length nn;
    // zd marks a zero-length completion, rstf an edge taken under reset.
    int act[2]  = '{0, 0};
    int kk[2]   = '{0, 0};
    int nn[2]   = '{0, 0};
    int zd[2]   = '{0, 0};
    int rstf[2] = '{0, 0};

    task automatic chk(input string tag, input int d, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s dut%0d cyc=%0d observed=%0h expected=%0h", tag, d, cyc, obs, exp);
        end
    endtask

    task automatic model(input int d, input logic s, input logic [3:0] nb, input logic ab);
        int   rel;
        logic was_busy;
        if (!rst_n) begin
            act[d]  = 0;
            zd[d]   = 0;
            rstf[d] = 1;
        end else begin
            zd[d]    = 0;
            rstf[d]  = 0;
            rel      = cyc - kk[d];
            was_busy = (act[d] != 0) && (rel >= 1) && (rel <= 2 * nn[d] * hd[d]);
            if (was_busy) begin
                if (ab) begin
                    act[d] = 0;
                    $display("[TB] dut%0d cyc=%0d abort", d, cyc);
                end
            end else if (s) begin
                if (nb == 4'd0) begin
                    zd[d] = 1;
                    $display("[TB] dut%0d cyc=%0d zero-length request", d, cyc);
                end else begin
                    act[d] = 1;
                    kk[d]  = cyc;
                    nn[d]  = (int'(nb) > NMAX) ? NMAX : int'(nb);
                    $display("[TB] dut%0d cyc=%0d burst accepted n=%0d", d, cyc, nn[d]);
                end
            end
        end
    endtask

    task automatic check(input int d, input logic pad, input logic lead, input logic trail,
                         input logic busy, input logic done, input logic [3:0] bidx);
        int   rel;
        int   per;
        int   ph;
        logic on;
        logic e_pad;
        logic e_done;
        rel    = cyc - kk[d];
        per    = 2 * hd[d];
        ph     = rel % per;
        on     = (act[d] != 0) && (rel < nn[d] * per);
        e_pad  = (on && ph < hd[d]) ? ~il[d] : il[d];
        e_done = (zd[d] != 0) || ((act[d] != 0) && (rel == nn[d] * per));
        chk("busy",      d, {7'd0, busy},  {7'd0, on});
        chk("pad_clk",   d, {7'd0, pad},   {7'd0, e_pad});
        chk("lead_stb",  d, {7'd0, lead},  {7'd0, on && ph == 0});
        chk("trail_stb", d, {7'd0, trail}, {7'd0, on && ph == hd[d]});
        chk("done",      d, {7'd0, done},  {7'd0, e_done});
        if (on || rstf[d] != 0) begin
            chk("bit_idx", d, {4'd0, bidx}, on ? 8'(rel / per) : 8'd0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model(0, bus0.start, bus0.nbits, bus0.abort);
        model(1, bus1.start, bus1.nbits, bus1.abort);
        #1;
        check(0, bus0.pad_clk, bus0.lead_stb, bus0.trail_stb, bus0.busy, bus0.done, bus0.bit_idx);
        check(1, bus1.pad_clk, bus1.lead_stb, bus1.trail_stb, bus1.busy, bus1.done, bus1.bit_idx);
    endtask

    initial begin
        // Reset held 3 cycles with start asserted: nothing may begin.
        bus0.start = 1'b1; bus0.nbits = 4'd8; bus0.abort = 1'b0;
        bus1.start = 1'b1; bus1.nbits = 4'd1; bus1.abort = 1'b0;
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();                       // release edge accepts both requests
        bus0.start = 1'b0;
        repeat (20) step();           // dut1: start held, back-to-back 1-bit bursts
        bus1.start = 1'b0;
        repeat (830) step();          // dut0: full 8-bit burst completes

        // Zero-length requests.
        bus0.start = 1'b1; bus0.nbits = 4'd0;
        bus1.start = 1'b1; bus1.nbits = 4'd0;
        step();
        bus0.start = 1'b0; bus1.start = 1'b0;
        repeat (5) step();

        // Oversized request is clamped to NBITS_MAX.
        bus1.start = 1'b1; bus1.nbits = 4'd15;
        step();
        bus1.start = 1'b0;
        repeat (40) step();

        // Abort during the ACT half of bit 3, then a clean burst.
        bus0.start = 1'b1; bus0.nbits = 4'd8;
        step();
        bus0.start = 1'b0;
        repeat (3 * 2 * H0 + 20) step();
        bus0.abort = 1'b1;
        step();
        bus0.abort = 1'b0;
        repeat (5) step();
        bus0.start = 1'b1;
        step();
        bus0.start = 1'b0;
        repeat (810) step();

        // Extra starts while busy, then reset at bit 5.
        bus0.start = 1'b1; bus0.nbits = 4'd8;
        bus1.start = 1'b1; bus1.nbits = 4'd8;
        step();
        for (int i = 0; i < 5 * 2 * H0 + 10; i++) begin
            bus0.start = 1'($urandom_range(0, 1));
            bus1.start = 1'($urandom_range(0, 1));
            step();
        end
        rst_n = 1'b0; bus0.start = 1'b0; bus1.start = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (5) step();

        // Randomised traffic.
        for (int i = 0; i < 4000; i++) begin
            bus0.start = ($urandom_range(0, 9) == 0);
            bus0.nbits = 4'($urandom_range(0, 15));
            bus0.abort = ($urandom_range(0, 299) == 0);
            bus1.start = ($urandom_range(0, 3) == 0);
            bus1.nbits = 4'($urandom_range(0, 15));
            bus1.abort = ($urandom_range(0, 49) == 0);
            step();
        end
        bus0.start = 1'b0; bus0.abort = 1'b0;
        bus1.start = 1'b0; bus1.abort = 1'b0;
        repeat (900) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pad_sclk_burst_gen.md
# pad_sclk_burst_gen

Parametrised pad clock generator that replaces the free-running 500 kHz pad clock divider. It emits gated bursts of exactly `nbits` pad clock cycles on request and holds a configurable idle level between bursts. It also provides one-cycle shift/sample strobes in the `clk_50mhz` domain so the byte shifter stays synchronous to the pad clock. It sits between the transaction sequencer (start/done handshake) and the pad pins (`pad_clk`).

## Interface
- `HALF_DIV`, 50: `clk_50mhz` cycles per pad clock half-period; ≥ 2. The default gives 500 kHz.
- `IDLE_LEVEL`, 1'b1: `pad_clk` level while idle and in the second half of each bit.
- `NBITS_MAX`, 8: largest burst length accepted.
- `clk_50mhz`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  burst request; sampled only in IDLE.
- `nbits`  in  $clog2(NBITS_MAX+1)  burst length, captured on accept.
- `abort`  in  1  cancel the burst in progress.
- `pad_clk`  out  1  pad clock, registered.
- `lead_stb`  out  1  one-cycle pulse coincident with each idle→active edge; the shift/drive edge.
- `trail_stb`  out  1  one-cycle pulse coincident with each active→idle edge; the sample edge.
- `bit_idx`  out  $clog2(NBITS_MAX+1)  index of the current bit, 0..nbits-1; valid while busy.
- `busy`  out  1  burst in progress.
- `done`  out  1  one-cycle pulse when a burst completes normally.

## Operation
- Reset values (when `rst_n`=0 at a clock edge): `pad_clk`=IDLE_LEVEL; `lead_stb`, `trail_stb`, `busy`, `done` = 0; `bit_idx`=0; state IDLE; half counter = 0.
  - Reset mid-burst aborts the burst silently. No `done` is issued.
- States:
  - IDLE.
  - ACT: first half of a bit; `pad_clk`=~IDLE_LEVEL.
  - REST: second half of a bit; `pad_clk`=IDLE_LEVEL.
- Half counter runs 0..HALF_DIV-1 in ACT and REST. It is cleared on every state change.
- IDLE, `start`=1, `nbits`≥1 (outputs change on the next edge):
  - state ACT, `pad_clk` active, `lead_stb`=1, `busy`=1, `bit_idx`=0.
  - `nbits` is latched.
- IDLE, `start`=1, `nbits`=0: `done`=1 on the next edge. `busy` and `pad_clk` do not change.
- IDLE, `start`=1, `nbits`>NBITS_MAX: clamp to NBITS_MAX.
- ACT with counter = HALF_DIV-1: move to REST, `pad_clk` idle, `trail_stb`=1.
- REST with counter = HALF_DIV-1:
  - If `bit_idx` < latched-1: move to ACT, `bit_idx`+1, `lead_stb`=1.
  - Otherwise: move to IDLE, `busy`=0, `done`=1.
- `abort`=1 in ACT or REST has priority over all other transitions. Next edge:
  - state IDLE, `pad_clk`=IDLE_LEVEL, `busy`=0.
  - No strobe and no `done`.
  - A trailing edge that this forces on `pad_clk` raises no `trail_stb`.
- `abort` in IDLE is ignored. If `abort` and `start` are both high in IDLE, the start is accepted.
- `start` while busy is ignored. Back-to-back bursts: `start` is accepted in the cycle `done`=1, because the state is already IDLE then.

## Timing
- Accept at edge k; H = HALF_DIV, n = latched `nbits`.
  - Leading edges at k + 2iH, i = 0..n-1.
  - Trailing edges at k + (2i+1)H.
  - `done` high and `busy` low from edge k + 2nH.
- `busy` is high for exactly 2nH cycles. The last REST half provides the trailing idle gap.
- Each strobe is high for exactly one cycle, the same cycle in which `pad_clk` shows the new level. All outputs are registered, with no combinational path from inputs.
- Pad clock period is 2H cycles at 50% duty.

## Structure
- Shared package `pad_pkg`:
  - `pad_sclk_state_e` enum {IDLE, ACT, REST}.
  - Constant `PAD_CLK_HZ_DEFAULT` = 500_000.
  - Function `half_div(clk_hz, sclk_hz)` = clk_hz/(2·sclk_hz).
- Sub-module `pad_half_tick`: a parametrised counter with synchronous clear and a terminal-count output `tc`. Its width is $clog2(HALF_DIV).
- All other logic lives in the top.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `start`=1 → `pad_clk`=1, `busy`=0, all strobes 0, no burst begins until the release edge.
- HALF_DIV=50, `nbits`=8, one `start` pulse → 8 `lead_stb` pulses 100 cycles apart, 8 `trail_stb` pulses 50 cycles after each, `busy` high for 800 cycles, then `done` for 1 cycle. `bit_idx` steps 0..7.
- HALF_DIV=2, `nbits`=1, IDLE_LEVEL=0 → `pad_clk` 1,1,0,0; `done` at cycle 4 after accept; `start` held high then starts a second burst the same cycle `done`=1.
- `nbits`=0 → `done` on the next cycle, `busy` never high, `pad_clk` static.
- `abort` at bit 3 mid-ACT (HALF_DIV=50) → next cycle `pad_clk`=IDLE_LEVEL, `busy`=0, no `done`, no strobe. A subsequent `start` gives a clean 8-bit burst.
- `start` pulsed repeatedly while busy, and `rst_n` pulled low at bit 5 → bursts unaffected by the extra starts; reset returns every output to its reset value with no `done`.
